// File: rtl/clock_divider_prog.sv
// Programmable integer clock divider: clk_out is low for floor(N/2) and high for ceil(N/2) input cycles.
// New divisors are queued in a single-entry slot and take effect only at a period boundary.
module clock_divider_prog #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_bits,
    output logic             div_ready,
    output logic             clk_out,
    output logic [WIDTH-1:0] div_active,
    output logic             period_done
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_active;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_vld;
    logic             r_clk_out;

    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_bits_clamped;
    logic             w_wrap;
    logic             w_xfer;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_pend_div_nxt;
    logic             w_pend_vld_nxt;
    logic             w_clk_nxt;

    assign w_last         = r_div_active - WIDTH'(1);
    assign w_wrap         = enable && (r_cnt == w_last);
    assign w_bits_clamped = (div_bits < WIDTH'(2)) ? WIDTH'(2) : div_bits;
    assign div_ready      = !r_pend_vld && !reset;
    assign w_xfer         = div_valid && div_ready;
    assign period_done    = w_wrap && !reset;
    assign clk_out        = r_clk_out;
    assign div_active     = r_div_active;

    // A boundary is either a wrap or any disabled cycle; only there may the divisor change.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_div_nxt      = r_div_active;
        w_pend_div_nxt = r_pend_div;
        w_pend_vld_nxt = r_pend_vld;
        if (!enable || w_wrap) begin
            w_cnt_nxt = '0;
            if (r_pend_vld) begin
                w_div_nxt      = r_pend_div;
                w_pend_vld_nxt = 1'b0;
            end else if (w_xfer) begin
                w_div_nxt = w_bits_clamped;
            end
        end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
            if (w_xfer) begin
                w_pend_div_nxt = w_bits_clamped;
                w_pend_vld_nxt = 1'b1;
            end
        end
        // Output is derived from next-state so the flop holds the phase of the coming cycle.
        w_clk_nxt = enable && (w_cnt_nxt >= (w_div_nxt >> 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_div_active <= WIDTH'(RESET_DIV);
            r_pend_div   <= '0;
            r_pend_vld   <= 1'b0;
            r_clk_out    <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_div_active <= w_div_nxt;
            r_pend_div   <= w_pend_div_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_clk_out    <= w_clk_nxt;
        end
    end

    a_div_legal: assert property (@(posedge clock) disable iff (reset)
        r_div_active >= WIDTH'(2));

    a_disabled_low: assert property (@(posedge clock) disable iff (reset)
        !enable |=> !r_clk_out);

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed bench for clock_divider_prog: per-period expectations are queued by the stimulus
// and checked by a monitor that measures each completed clk_out period.
module tb_clock_divider_prog;

    localparam int unsigned WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             div_valid = 1'b0;
    logic [WIDTH-1:0] div_bits = '0;
    logic             div_ready;
    logic             clk_out;
    logic [WIDTH-1:0] div_active;
    logic             period_done;

    clock_divider_prog #(.WIDTH(WIDTH), .RESET_DIV(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .div_valid   (div_valid),
        .div_bits    (div_bits),
        .div_ready   (div_ready),
        .clk_out     (clk_out),
        .div_active  (div_active),
        .period_done (period_done)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int div;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int div, input int count);
        exp_t e;
        e.div = div;
        e.lo  = div / 2;
        e.hi  = div - div / 2;
        for (int i = 0; i < count; i++) exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    // Monitor: measures low/high run lengths and checks each period at its period_done cycle.
    int lo_cnt = 0;
    int hi_cnt = 0;
    always @(negedge clock) begin
        if (reset || !enable) begin
            lo_cnt = 0;
            hi_cnt = 0;
        end else begin
            if (clk_out) hi_cnt++;
            else         lo_cnt++;
            if (period_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_period", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("period_div_active", int'(div_active), e.div);
                    check("period_low_len", lo_cnt, e.lo);
                    check("period_high_len", hi_cnt, e.hi);
                end
                lo_cnt = 0;
                hi_cnt = 0;
            end
        end
    end

    initial begin
        // Reset with enable high and a transfer attempt that must be dropped.
        tick();
        reset = 1'b1; enable = 1'b1; div_valid = 1'b1; div_bits = 8'd9;
        tick();
        #3;
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_div_active", int'(div_active), 2);
        check("rst_div_ready", int'(div_ready), 0);
        check("rst_period_done", int'(period_done), 0);
        tick();
        cyc = 0;
        reset = 1'b0; div_valid = 1'b0;
        push(2, 4);
        #3;
        check("rel_div_ready", int'(div_ready), 1);
        check("rel_div_active", int'(div_active), 2);
        check("rel_clk_out", int'(clk_out), 0);

        goto(1); #3;
        check("div2_clk_high", int'(clk_out), 1);
        check("div2_period_done", int'(period_done), 1);

        // Queued request of 5 mid-period.
        goto(6);
        div_valid = 1'b1; div_bits = 8'd5;
        push(5, 2);
        #3;
        check("n5_ready_before", int'(div_ready), 1);
        goto(7);
        div_valid = 1'b0;
        #3;
        check("n5_ready_pending", int'(div_ready), 0);
        check("n5_old_div", int'(div_active), 2);
        goto(8); #3;
        check("n5_div_active", int'(div_active), 5);
        check("n5_ready_after", int'(div_ready), 1);

        // Bypass of 7 in a wrap cycle.
        goto(17);
        div_valid = 1'b1; div_bits = 8'd7;
        push(7, 1);
        #3;
        check("n7_wrap_cycle", int'(period_done), 1);
        check("n7_ready", int'(div_ready), 1);
        goto(18);
        div_valid = 1'b0;
        #3;
        check("n7_div_active", int'(div_active), 7);
        check("n7_ready_stays", int'(div_ready), 1);

        // Divisor 0 clamps to 2.
        goto(19);
        div_valid = 1'b1; div_bits = 8'd0;
        push(2, 1);
        goto(20);
        div_valid = 1'b0;
        #3;
        check("n0_ready_pending", int'(div_ready), 0);
        check("n0_old_div", int'(div_active), 7);

        // Maximum divisor 255.
        goto(25);
        div_valid = 1'b1; div_bits = 8'd255;
        push(255, 1);
        #3;
        check("n0_clamped", int'(div_active), 2);
        goto(26);
        div_valid = 1'b0;
        goto(27); #3;
        check("n255_div_active", int'(div_active), 255);

        // Pending 9, then drop enable in the high phase.
        goto(283);
        div_valid = 1'b1; div_bits = 8'd9;
        goto(284);
        div_valid = 1'b0;
        #3;
        check("n9_ready_pending", int'(div_ready), 0);
        check("n9_old_div", int'(div_active), 255);
        goto(482);
        enable = 1'b0;
        #3;
        check("dis_clk_high_before", int'(clk_out), 1);
        check("dis_period_done", int'(period_done), 0);
        goto(483); #3;
        check("dis_clk_low", int'(clk_out), 0);
        check("dis_div_applied", int'(div_active), 9);
        check("dis_ready", int'(div_ready), 1);
        check("dis_period_done2", int'(period_done), 0);

        // While disabled, transfers apply directly; 1 clamps to 2.
        goto(484);
        div_valid = 1'b1; div_bits = 8'd1;
        goto(485);
        div_bits = 8'd9;
        #3;
        check("dis_clamp1", int'(div_active), 2);
        check("dis_ready2", int'(div_ready), 1);
        goto(486);
        div_valid = 1'b0; enable = 1'b1;
        push(9, 1);
        #3;
        check("en_div_active", int'(div_active), 9);
        check("en_clk_low", int'(clk_out), 0);

        // Reset in the high phase with 6 pending.
        goto(496);
        div_valid = 1'b1; div_bits = 8'd6;
        goto(497);
        div_valid = 1'b0;
        #3;
        check("n6_ready_pending", int'(div_ready), 0);
        goto(500);
        reset = 1'b1;
        #3;
        check("midrst_clk_high", int'(clk_out), 1);
        check("midrst_ready", int'(div_ready), 0);
        check("midrst_period_done", int'(period_done), 0);
        goto(501); #3;
        check("midrst_clk_low", int'(clk_out), 0);
        check("midrst_div", int'(div_active), 2);
        check("midrst_ready2", int'(div_ready), 0);
        goto(502);
        reset = 1'b0;
        push(2, 3);
        #3;
        check("postrst_ready", int'(div_ready), 1);
        check("postrst_div", int'(div_active), 2);
        check("postrst_clk", int'(clk_out), 0);

        goto(508);
        enable = 1'b0;
        goto(511);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
